la_irqagg: RTL and testbench

LA_IRQAGG -- requirements
Module: la_irqagg

---
 rtl/la_irqagg_pkg.sv | 19 +
 rtl/la_dsync.sv | 30 +++
 rtl/la_irqagg.sv | 119 +++++++++++
 tb/tb_la_irqagg.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/la_irqagg_pkg.sv
// ============================================================================
// la_irqagg_pkg : shared FSM encoding and synchronizer depth for la_irqagg
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package la_irqagg_pkg;

  localparam int LA_IRQAGG_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/la_dsync.sv
// ============================================================================
// la_dsync : single-bit multi-flop synchronizer, flops clear on reset
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module la_dsync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic in,
  output logic out
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], in};
    end
  end

  assign out = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/la_irqagg.sv
// ============================================================================
// la_irqagg : edge-detecting interrupt aggregator with holdoff and event count
// Optional input synchronizers enabled by macro LA_IRQAGG_SYNC_EN. Rev 1.0
// ============================================================================
`default_nettype none

module la_irqagg
  import la_irqagg_pkg::*;
#(
  parameter     PROP = "DEFAULT",
  parameter int N    = 3,
  parameter int HOLD = 4,
  parameter int CW   = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [N-1:0]  in,
  input  logic [N-1:0]  mask,
  input  logic [N-1:0]  clear,
  input  logic          cnt_clr,
  output logic [N-1:0]  status,
  output logic          z,
  output logic [CW-1:0] count
);

  logic [N-1:0]  w_in;
  logic [N-1:0]  w_edge;
  logic          w_pending;
  logic          w_any_unmasked;
  logic [N-1:0]  prev_q;
  logic [N-1:0]  status_q, status_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    hold_q, hold_d;
  logic          z_q, z_d;
  state_t        state_q, state_d;

`ifdef LA_IRQAGG_SYNC_EN
  for (genvar gi = 0; gi < N; gi++) begin : g_sync
    la_dsync #(
      .STAGES (LA_IRQAGG_SYNC_STAGES)
    ) u_dsync (
      .clk    (clk),
      .nreset (nreset),
      .in     (in[gi]),
      .out    (w_in[gi])
    );
  end
`else
  assign w_in = in;
`endif

  assign w_edge         = w_in & ~prev_q;
  assign w_pending      = |(status_q & ~mask);
  assign w_any_unmasked = |(w_edge & ~mask);

  // Set wins over clear on the same bit.
  assign status_d = (status_q & ~clear) | w_edge;

  always_comb begin
    count_d = count_q;
    if (cnt_clr) begin
      count_d = '0;
    end else if (w_any_unmasked && (count_q != {CW{1'b1}})) begin
      count_d = count_q + CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (w_pending) state_d = ASSERT;
      end
      ASSERT: begin
        if (!w_pending) begin
          if (HOLD == 0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLDOFF;
            hold_d  = 8'(HOLD - 1);
          end
        end
      end
      HOLDOFF: begin
        // Pending sources are ignored until the holdoff window expires.
        if (hold_q == 8'd0) state_d = IDLE;
        else                hold_d  = hold_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    z_d = (state_d == ASSERT);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      prev_q   <= '0;
      status_q <= '0;
      count_q  <= '0;
      hold_q   <= 8'd0;
      z_q      <= 1'b0;
      state_q  <= IDLE;
    end else begin
      prev_q   <= w_in;
      status_q <= status_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
      z_q      <= z_d;
      state_q  <= state_d;
    end
  end

  assign status = status_q;
  assign z      = z_q;
  assign count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_la_irqagg.sv
// ============================================================================
// tb_la_irqagg : scoreboard bench for la_irqagg (N=3, HOLD=4, CW=8)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_la_irqagg;

  localparam int N  = 3;
  localparam int CW = 8;
`ifdef LA_IRQAGG_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic          clk = 1'b0;
  logic          nreset;
  logic [N-1:0]  in, mask, clear;
  logic          cnt_clr;
  logic [N-1:0]  status;
  logic          z;
  logic [CW-1:0] count;

  la_irqagg #(
    .PROP ("DEFAULT"),
    .N    (N),
    .HOLD (4),
    .CW   (CW)
  ) dut (
    .clk     (clk),
    .nreset  (nreset),
    .in      (in),
    .mask    (mask),
    .clear   (clear),
    .cnt_clr (cnt_clr),
    .status  (status),
    .z       (z),
    .count   (count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void expect_at(int at, int kind, logic [31:0] v);
    exp_t e;
    e.at = at; e.kind = kind; e.val = v;
    q.push_back(e);
  endfunction

  function automatic logic [31:0] actual(int kind);
    case (kind)
      0:       return 32'(status);
      1:       return 32'(z);
      default: return 32'(count);
    endcase
  endfunction

  function automatic string kname(int kind);
    case (kind)
      0:       return "status";
      1:       return "z";
      default: return "count";
    endcase
  endfunction

  // Monitor: compares every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at == cyc) begin
        n_cmp++;
        if (actual(q[i].kind) !== q[i].val) begin
          n_bad++;
          $display("FAIL %s @cycle %0d: got %0h, want %0h",
                   kname(q[i].kind), cyc, actual(q[i].kind), q[i].val);
        end
        q.delete(i);
      end else if (q[i].at < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s @cycle %0d: check missed, want %0h",
                 kname(q[i].kind), q[i].at, q[i].val);
        q.delete(i);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int b, t, m, r;

  initial begin
    nreset = 1'b0; in = '0; mask = '0; clear = '0; cnt_clr = 1'b0;
    tick(2);
    expect_at(cyc, 0, 0); expect_at(cyc, 1, 0); expect_at(cyc, 2, 0);
    nreset = 1'b1;
    tick(3);

    // Single-cycle pulse on bit 1
    b = cyc; in = 3'b010;
    expect_at(b+1+L, 0, 3'b010); expect_at(b+1+L, 1, 0);
    expect_at(b+2+L, 1, 1);      expect_at(b+2+L, 2, 1);
    tick; in = '0;
    tick(3+L); clear = 3'b010; tick; clear = '0; tick(8);

    // Clear drops z, new edge lands in holdoff and waits for IDLE
    b = cyc; in = 3'b001; tick; in = '0; tick(2+L);
    t = cyc;
    expect_at(t, 1, 1); clear = 3'b001;
    expect_at(t+1, 0, 0); expect_at(t+1, 1, 1); expect_at(t+2, 1, 0);
    tick; clear = '0; tick(2);
    in = 3'b100;
    expect_at(t+4+L, 0, 3'b100); expect_at(t+4+L, 2, 3);
    for (int k = 3; k <= 6; k++) expect_at(t+k, 1, 0);
    expect_at(t+7, 1, 1);
    tick; in = '0; tick(5);
    clear = 3'b100; tick; clear = '0; tick(8);

    // Fully masked edge, then unmask
    mask = 3'b111; b = cyc; in = 3'b001;
    expect_at(b+1+L, 0, 3'b001); expect_at(b+2+L, 1, 0); expect_at(b+2+L, 2, 3);
    tick; in = '0; tick(2+L);
    m = cyc; mask = 3'b110;
    expect_at(m, 1, 0); expect_at(m+1, 1, 1);
    tick(2); clear = 3'b001; tick; clear = '0; mask = '0; tick(8);

    // Edge and clear on the same bit in the same cycle
    in = 3'b010; tick(L);
    clear = 3'b010;
    expect_at(cyc+1, 0, 3'b010); expect_at(cyc+1, 2, 4);
    tick; clear = '0; in = '0; tick(1+L);
    clear = 3'b010; tick; clear = '0; tick;

    // 300 edge cycles saturate the counter; cnt_clr beats an edge
    b = cyc;
    for (int k = 0; k < 300; k++) begin
      in = (k % 2 == 0) ? 3'b001 : 3'b010;
      tick;
    end
    expect_at(cyc, 2, 255);
    in = 3'b001; cnt_clr = 1'b1;
    expect_at(cyc+1, 2, 0);
    tick; cnt_clr = 1'b0; in = '0; clear = 3'b111; tick(4); clear = '0; tick(8);

    // Reset during HOLDOFF, input held high through release
    b = cyc; in = 3'b100; tick; in = '0; tick(1+L);
    expect_at(cyc, 1, 1); clear = 3'b100;
    tick; clear = '0; tick;
    expect_at(cyc, 1, 0);
    tick;
    nreset = 1'b0; in = 3'b111;
    expect_at(cyc+1, 0, 0); expect_at(cyc+1, 1, 0); expect_at(cyc+1, 2, 0);
    tick(2); nreset = 1'b1; r = cyc;
    expect_at(r+1+L, 0, 3'b111); expect_at(r+1+L, 2, 1);
    expect_at(r+1+L, 1, 0);      expect_at(r+2+L, 1, 1);
    tick(4+L);

    for (int i = 0; i < 50 && q.size() > 0; i++) tick;
    while (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s @cycle %0d: never checked, want %0h",
               kname(q[0].kind), q[0].at, q[0].val);
      void'(q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
